fft_frame_ctrl: RTL and testbench



---
 rtl/fft_frame_ctrl_pkg.sv | 19 +
 rtl/fft_frame_ctrl_if.sv | 22 ++
 rtl/fft_frame_ctrl_outreg.sv | 57 +++++
 rtl/fft_frame_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_frame_ctrl_pkg.sv
// Shared types and defaults for the FFT frame sequencer.
package fft_frame_ctrl_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    FILL  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 15;
  localparam int DEF_LEN_W  = 12;
  localparam int DEF_NFR_W  = 8;

  // Data value carried by the pad word that closes an aborted frame
  localparam int PAD_WORD = 0;

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// Avalon-ST style packet bus between the frame sequencer and the FFT FIFO.
interface fft_frame_ctrl_if
  import fft_frame_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_valid;
  logic              fifo_ready;
  logic              fifo_sop;
  logic              fifo_eop;

  modport master (
    output fifo_data, fifo_valid, fifo_sop, fifo_eop,
    input  fifo_ready
  );

  modport slave (
    input  fifo_data, fifo_valid, fifo_sop, fifo_eop,
    output fifo_ready
  );
endinterface

// File: rtl/fft_frame_ctrl_outreg.sv
// One-deep holding register driving the packet bus. A pad word or a new
// sample may only be loaded when the register is empty or draining this
// cycle; force_eop only touches a word that is stalled in place.
module fft_frame_ctrl_outreg
  import fft_frame_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_sop,
  input  logic              load_eop,
  input  logic              force_eop,
  input  logic              pad_ins,
  fft_frame_ctrl_if.master  fifo
);

  logic [DATA_W-1:0] data_p0;
  logic              sop_p0;
  logic              eop_p0;
  logic              vld_p0;

  // Holding stage: pad insert, sample load, or hold/release of current word
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      data_p0 <= '0;
      sop_p0  <= 1'b0;
      eop_p0  <= 1'b0;
      vld_p0  <= 1'b0;
    end else if (pad_ins) begin
      data_p0 <= DATA_W'(PAD_WORD);
      sop_p0  <= 1'b0;
      eop_p0  <= 1'b1;
      vld_p0  <= 1'b1;
    end else if (load) begin
      data_p0 <= load_data;
      sop_p0  <= load_sop;
      eop_p0  <= load_eop;
      vld_p0  <= 1'b1;
    end else begin
      if (force_eop) begin
        eop_p0 <= 1'b1;
      end
      if (vld_p0 && fifo.fifo_ready) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign fifo.fifo_data  = data_p0;
  assign fifo.fifo_sop   = sop_p0;
  assign fifo.fifo_eop   = eop_p0;
  assign fifo.fifo_valid = vld_p0;

endmodule

// File: rtl/fft_frame_ctrl.sv
// FFT frame sequencer: arms on start, begins on trig, and cuts the
// non-stallable ADC stream into cfg_nfr_m1+1 packets of cfg_len_m1+1 words.
// Optional feature: define FFT_FRAME_CTRL_OVF_CNT_EN to add ovf_cnt, a
// saturating 16-bit count of dropped samples.
module fft_frame_ctrl
  import fft_frame_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int NFR_W  = DEF_NFR_W
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              trig,
  input  logic [LEN_W-1:0]  cfg_len_m1,
  input  logic [NFR_W-1:0]  cfg_nfr_m1,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  fft_frame_ctrl_if.master  fifo,
  output logic              busy,
  output logic              done,
  output logic              ovf,
`ifdef FFT_FRAME_CTRL_OVF_CNT_EN
  output logic [15:0]       ovf_cnt,
`endif
  output logic [NFR_W-1:0]  frame_idx
);

  state_t state, state_nxt;

  logic [LEN_W-1:0] len_m1;
  logic [NFR_W-1:0] nfr_m1;
  logic [LEN_W-1:0] cnt;

  logic hold_stall;
  logic in_win;
  logic frame_open;
  logic word_sop;
  logic word_eop;
  logic last_word;

  logic start_go;
  logic abort_go;
  logic accept;
  logic drop;
  logic force_eop;
  logic pad_ins;

  // A held word that cannot leave this cycle blocks any new load
  assign hold_stall = fifo.fifo_valid && !fifo.fifo_ready;
  assign in_win     = (state == FILL) || ((state == ARM) && trig);
  // cnt returns to 0 after every eop, so nonzero means a packet is open
  assign frame_open = (cnt != '0);
  assign word_sop   = (cnt == '0);
  assign word_eop   = (cnt == len_m1);
  assign last_word  = word_eop && (frame_idx == nfr_m1);

  // State register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle control decisions; abort beats a coincident sample
  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    abort_go  = 1'b0;
    accept    = 1'b0;
    drop      = 1'b0;
    force_eop = 1'b0;
    pad_ins   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_go  = 1'b1;
          state_nxt = ARM;
        end
      end
      ARM: begin
        if (trig) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
      end
      DRAIN: begin
        if (!fifo.fifo_valid) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (((state == ARM) || (state == FILL)) && abort) begin
      abort_go  = 1'b1;
      state_nxt = DRAIN;
      force_eop = frame_open && hold_stall;
      pad_ins   = frame_open && !hold_stall;
    end else if (in_win && adc_valid) begin
      accept = !hold_stall;
      drop   = hold_stall;
      if (accept && last_word) begin
        state_nxt = DRAIN;
      end
    end
  end

  // Config latch, sample/frame counters and sticky overflow flag
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      len_m1    <= '0;
      nfr_m1    <= '0;
      cnt       <= '0;
      frame_idx <= '0;
      ovf       <= 1'b0;
    end else if (start_go) begin
      len_m1    <= cfg_len_m1;
      nfr_m1    <= cfg_nfr_m1;
      cnt       <= '0;
      frame_idx <= '0;
      ovf       <= 1'b0;
    end else begin
      if (abort_go) begin
        cnt <= '0;
      end else if (accept) begin
        if (word_eop) begin
          cnt <= '0;
          if (!last_word) begin
            frame_idx <= frame_idx + 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

`ifdef FFT_FRAME_CTRL_OVF_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating dropped-sample counter, cleared by start
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ovf_cnt <= '0;
    end else if (start_go) begin
      ovf_cnt <= '0;
    end else if (drop) begin
      ovf_cnt <= sat_inc16(ovf_cnt);
    end
  end
`endif

  assign busy = (state != IDLE);
  assign done = (state == DRAIN) && !fifo.fifo_valid;

  fft_frame_ctrl_outreg #(
    .DATA_W (DATA_W)
  ) u_outreg (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .load          (accept),
    .load_data     (adc_data),
    .load_sop      (word_sop),
    .load_eop      (word_eop),
    .force_eop     (force_eop),
    .pad_ins       (pad_ins),
    .fifo          (fifo)
  );

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a
// sample-position model of the sequencer.
module tb_fft_frame_ctrl;

  localparam int S_IDLE  = 0;
  localparam int S_ARM   = 1;
  localparam int S_FILL  = 2;
  localparam int S_DRAIN = 3;

  typedef struct packed {
    logic [14:0] d;
    logic        s;
    logic        e;
  } word_t;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        trig = 1'b0;
  logic [11:0] cfg_len_m1 = '0;
  logic [7:0]  cfg_nfr_m1 = '0;
  logic [14:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [7:0]  frame_idx;
`ifdef FFT_FRAME_CTRL_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  fft_frame_ctrl_if #(.DATA_W(15)) fifo_if ();

  fft_frame_ctrl dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .start         (start),
    .abort         (abort),
    .trig          (trig),
    .cfg_len_m1    (cfg_len_m1),
    .cfg_nfr_m1    (cfg_nfr_m1),
    .adc_data      (adc_data),
    .adc_valid     (adc_valid),
    .fifo          (fifo_if.master),
    .busy          (busy),
    .done          (done),
    .ovf           (ovf),
`ifdef FFT_FRAME_CTRL_OVF_CNT_EN
    .ovf_cnt       (ovf_cnt),
`endif
    .frame_idx     (frame_idx)
  );

  always #5 clk_clk = ~clk_clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit auto_data = 1'b1;

  // Observation log
  word_t log_q[$];
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_hs_cyc = -1;
  int busy_fall_cyc = -1;
  bit prev_busy = 1'b0;

  // Reference model: the acquisition is described by how many samples have
  // been accepted so far; sop/eop/frame index/last word follow by division.
  int    m_st = S_IDLE;
  int    m_len = 0;
  int    m_nfr = 0;
  int    m_acc = 0;
  bit    m_ovf = 1'b0;
  int    m_ovfcnt = 0;
  bit    m_v = 1'b0;
  int    m_d = 0;
  bit    m_s = 1'b0;
  bit    m_e = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_fidx();
    int f;
    f = m_acc / (m_len + 1);
    return (f > m_nfr) ? m_nfr : f;
  endfunction

  always @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      m_st = S_IDLE; m_len = 0; m_nfr = 0; m_acc = 0;
      m_ovf = 1'b0; m_ovfcnt = 0;
      m_v = 1'b0; m_d = 0; m_s = 1'b0; m_e = 1'b0;
    end else begin
      int  L;
      int  N;
      int  pos;
      bit  v_pre;
      bit  stall;
      bit  win;
      L = m_len + 1;
      N = m_nfr + 1;
      pos = m_acc % L;
      v_pre = m_v;
      stall = m_v && !fifo_if.fifo_ready;
      if (m_v && fifo_if.fifo_ready) m_v = 1'b0;
      case (m_st)
        S_IDLE: begin
          if (start) begin
            m_st = S_ARM;
            m_len = int'(cfg_len_m1);
            m_nfr = int'(cfg_nfr_m1);
            m_acc = 0; m_ovf = 1'b0; m_ovfcnt = 0;
          end
        end
        S_ARM, S_FILL: begin
          win = (m_st == S_FILL) || trig;
          if (abort) begin
            m_st = S_DRAIN;
            if (pos != 0) begin
              if (stall) m_e = 1'b1;
              else begin m_v = 1'b1; m_d = 0; m_s = 1'b0; m_e = 1'b1; end
            end
          end else if (win && adc_valid && stall) begin
            m_ovf = 1'b1;
            if (m_ovfcnt < 65535) m_ovfcnt++;
            m_st = S_FILL;
          end else if (win && adc_valid) begin
            m_v = 1'b1; m_d = int'(adc_data);
            m_s = (pos == 0); m_e = (pos == L - 1);
            m_st = (m_acc == L * N - 1) ? S_DRAIN : S_FILL;
            m_acc++;
          end else if (win) begin
            m_st = S_FILL;
          end
        end
        default: begin
          if (!v_pre) m_st = S_IDLE;
        end
      endcase
    end
  end

  // Per-cycle comparison against the model, plus the packet log
  always @(negedge clk_clk) begin
    cyc++;
    chk("busy", int'(busy), int'(m_st != S_IDLE));
    chk("done", int'(done), int'(m_st == S_DRAIN && !m_v));
    chk("ovf", int'(ovf), int'(m_ovf));
    chk("frame_idx", int'(frame_idx), exp_fidx());
    chk("fifo_valid", int'(fifo_if.fifo_valid), int'(m_v));
    if (m_v) begin
      chk("fifo_data", int'(fifo_if.fifo_data), m_d);
      chk("fifo_sop", int'(fifo_if.fifo_sop), int'(m_s));
      chk("fifo_eop", int'(fifo_if.fifo_eop), int'(m_e));
    end
`ifdef FFT_FRAME_CTRL_OVF_CNT_EN
    chk("ovf_cnt", int'(ovf_cnt), m_ovfcnt);
`endif
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (prev_busy && !busy) busy_fall_cyc = cyc;
    prev_busy = busy;
    if (fifo_if.fifo_valid && fifo_if.fifo_ready) begin
      log_q.push_back('{d: fifo_if.fifo_data, s: fifo_if.fifo_sop, e: fifo_if.fifo_eop});
      last_hs_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk_clk);
    #1;
    if (auto_data) adc_data = adc_data + 15'd1;
  endtask

  task automatic clear_log();
    log_q.delete();
    done_cnt = 0; done_cyc = -1; last_hs_cyc = -1; busy_fall_cyc = -1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while (busy && k < budget) begin tick(); k++; end
    if (busy) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, budget);
    end
    tick();
  endtask

  task automatic start_pulse();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    fifo_if.fifo_ready = 1'b0;
    tick(); tick();
    // Reset state
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(fifo_if.fifo_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_frame_idx", int'(frame_idx), 0);
    reset_reset_n = 1'b1;
    tick();

    // T1: two 4-word frames, no backpressure
    cfg_len_m1 = 12'd3; cfg_nfr_m1 = 8'd1;
    fifo_if.fifo_ready = 1'b1; adc_valid = 1'b1;
    clear_log();
    start_pulse();
    chk("t1_busy_rise", int'(busy), 1);
    trig = 1'b1; tick(); trig = 1'b0;
    wait_idle(50, "t1");
    adc_valid = 1'b0;
    chk("t1_words", log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      chk("t1_sop", int'(log_q[i].s), int'(i % 4 == 0));
      chk("t1_eop", int'(log_q[i].e), int'(i % 4 == 3));
      chk("t1_data_seq", int'(log_q[i].d), int'(15'(log_q[0].d + 15'(i))));
    end
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_after_last", done_cyc, last_hs_cyc + 1);
    chk("t1_busy_fall", busy_fall_cyc, done_cyc + 1);
    chk("t1_ovf", int'(ovf), 0);
    chk("t1_frame_idx", int'(frame_idx), 1);

    // T2: 2-cycle stall with one sample landing in it; start during FILL
    clear_log();
    adc_valid = 1'b1;
    start_pulse();
    trig = 1'b1; tick(); trig = 1'b0;
    tick();
    fifo_if.fifo_ready = 1'b0; adc_valid = 1'b1; tick();
    adc_valid = 1'b0; start = 1'b1; tick();
    start = 1'b0; fifo_if.fifo_ready = 1'b1; adc_valid = 1'b1;
    wait_idle(50, "t2");
    adc_valid = 1'b0;
    chk("t2_words", log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      chk("t2_sop", int'(log_q[i].s), int'(i % 4 == 0));
      chk("t2_eop", int'(log_q[i].e), int'(i % 4 == 3));
    end
    chk("t2_ovf", int'(ovf), 1);
    chk("t2_model_drops", m_ovfcnt, 1);
`ifdef FFT_FRAME_CTRL_OVF_CNT_EN
    chk("t2_ovf_cnt", int'(ovf_cnt), 1);
`endif
    chk("t2_done_cnt", done_cnt, 1);

    // T3: abort after word 2 with ready high -> pad word
    clear_log();
    start_pulse();
    adc_valid = 1'b1; trig = 1'b1; tick(); trig = 1'b0;
    tick(); tick();
    abort = 1'b1; tick(); abort = 1'b0;
    wait_idle(20, "t3");
    adc_valid = 1'b0;
    chk("t3_words", log_q.size(), 4);
    if (log_q.size() >= 4) begin
      chk("t3_w2_eop", int'(log_q[2].e), 0);
      chk("t3_pad_data", int'(log_q[3].d), 0);
      chk("t3_pad_sop", int'(log_q[3].s), 0);
      chk("t3_pad_eop", int'(log_q[3].e), 1);
    end
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_busy", int'(busy), 0);

    // T4: abort while a word is stalled -> word released with eop, no pad
    clear_log();
    start_pulse();
    adc_valid = 1'b1; trig = 1'b1; tick(); trig = 1'b0;
    fifo_if.fifo_ready = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
    chk("t4_held_valid", int'(fifo_if.fifo_valid), 1);
    chk("t4_forced_eop", int'(fifo_if.fifo_eop), 1);
    fifo_if.fifo_ready = 1'b1;
    wait_idle(20, "t4");
    adc_valid = 1'b0;
    chk("t4_words", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      chk("t4_sop", int'(log_q[0].s), 1);
      chk("t4_eop", int'(log_q[0].e), 1);
    end
    chk("t4_ovf", int'(ovf), 0);

    // T5: single-word frames
    clear_log();
    cfg_len_m1 = 12'd0; cfg_nfr_m1 = 8'd2;
    start_pulse();
    adc_valid = 1'b1; trig = 1'b1;
    chk("t5_fidx0", int'(frame_idx), 0);
    tick(); trig = 1'b0;
    chk("t5_fidx1", int'(frame_idx), 1);
    tick();
    chk("t5_fidx2", int'(frame_idx), 2);
    tick();
    chk("t5_fidx_last", int'(frame_idx), 2);
    wait_idle(20, "t5");
    adc_valid = 1'b0;
    chk("t5_words", log_q.size(), 3);
    foreach (log_q[i]) begin
      chk("t5_sop", int'(log_q[i].s), 1);
      chk("t5_eop", int'(log_q[i].e), 1);
    end

    // T6: reset mid-frame
    cfg_len_m1 = 12'd3; cfg_nfr_m1 = 8'd1;
    start_pulse();
    adc_valid = 1'b1; trig = 1'b1; tick(); trig = 1'b0;
    fifo_if.fifo_ready = 1'b0; tick(); tick();
    reset_reset_n = 1'b0; #1;
    chk("t6_valid", int'(fifo_if.fifo_valid), 0);
    chk("t6_data", int'(fifo_if.fifo_data), 0);
    chk("t6_sop", int'(fifo_if.fifo_sop), 0);
    chk("t6_eop", int'(fifo_if.fifo_eop), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_ovf", int'(ovf), 0);
    chk("t6_frame_idx", int'(frame_idx), 0);
    tick();
    reset_reset_n = 1'b1; adc_valid = 1'b0; fifo_if.fifo_ready = 1'b1;
    tick();

    // Randomized traffic with random config, backpressure, aborts and restarts
    auto_data = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      start      = ($urandom_range(0, 19) == 0);
      abort      = ($urandom_range(0, 79) == 0);
      trig       = ($urandom_range(0, 3) == 0);
      adc_valid  = ($urandom_range(0, 9) < 7);
      fifo_if.fifo_ready = ($urandom_range(0, 9) < 7);
      adc_data   = 15'($urandom);
      cfg_len_m1 = 12'($urandom_range(0, 5));
      cfg_nfr_m1 = 8'($urandom_range(0, 3));
      tick();
    end
    start = 1'b0; abort = 1'b0; trig = 1'b1; adc_valid = 1'b1;
    fifo_if.fifo_ready = 1'b1;
    wait_idle(200, "rand");
    trig = 1'b0; adc_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
